// File: rtl/buzzer_pkg.sv
// Purpose: shared types and constants for the buzzer note path (sequencer and note mux).
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: step index width, default last step (the mux case table is sized from it too),
// the sequencer state enum and a helper that computes the next step index.
package buzzer_pkg;

    localparam int STEP_W        = 8;
    localparam int DEF_LAST_STEP = 20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HOLD = 2'd2
    } seq_state_t;

    // Result of advancing one step: the new index, and whether a one-shot sequence ran off its end.
    typedef struct packed {
        logic [STEP_W-1:0] sel;
        logic              ended;
    } step_adv_t;

    // Next step index from the current one. Running off either end either wraps
    // (wrap=1) or flags the end of the sequence with sel returned to the silence entry.
    // The >= / == tests keep the result inside 0..last even if cur were ever out of range.
    function automatic step_adv_t step_advance(
        input logic [STEP_W-1:0] cur,
        input logic              up,
        input logic              wrap,
        input logic [STEP_W-1:0] last
    );
        step_adv_t r;
        r.sel   = cur;
        r.ended = 1'b0;
        if (up) begin
            if (cur >= last) begin
                r.sel   = '0;
                r.ended = ~wrap;
            end else begin
                r.sel = cur + STEP_W'(1);
            end
        end else begin
            if (cur == '0) begin
                r.sel   = wrap ? last : '0;
                r.ended = ~wrap;
            end else if (cur > last) begin
                r.sel = last;
            end else begin
                r.sel = cur - STEP_W'(1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Purpose: per-step tick counter; flags the last tick of a step and the note-sounding window.
// Latency: boundary/gate_win are decodes of the counter register (same cycle, no input path).
// Backpressure: none; run=0 freezes the count, clear forces it to 0 and wins over run.
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   run        - advance the counter this cycle (wraps to 0 after TICKS_PER_STEP-1)
//   clear      - return the counter to 0
//   boundary   - counter is at TICKS_PER_STEP-1 (step ends on this cycle's edge if run)
//   gate_win   - counter is below TICKS_PER_STEP-GAP_TICKS
module step_tick_gen #(
    parameter int TICKS_PER_STEP = 12_500_000,
    parameter int GAP_TICKS      = 1_250_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic boundary,
    output logic gate_win
);

    localparam int CNT_W = (TICKS_PER_STEP > 2) ? $clog2(TICKS_PER_STEP) : 1;

    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICKS_PER_STEP - 1);
    // One bit wider than the counter so a zero gap (window end == TICKS_PER_STEP)
    // does not truncate when TICKS_PER_STEP is a power of two.
    localparam logic [CNT_W:0]   GATE_END  = (CNT_W + 1)'(TICKS_PER_STEP - GAP_TICKS);

    logic [CNT_W-1:0] tick_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (clear) begin
            tick_cnt <= '0;
        end else if (run) begin
            if (tick_cnt == LAST_TICK) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + CNT_W'(1);
            end
        end
    end

    assign boundary = (tick_cnt == LAST_TICK);
    assign gate_win = ({1'b0, tick_cnt} < GATE_END);

endmodule

// File: rtl/melody_step_sequencer.sv
// Purpose: tempo-stepped note index for the buzzer mux, with start/stop/pause, loop/one-shot and gate.
// Latency: start seen at edge N -> playing=1 and first index on sel after edge N; done is registered.
// Backpressure: none; pause freezes the sequence in HOLD, stop aborts to IDLE (stop > start > pause).
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   start      - level; begins playback from IDLE (ignored while playing)
//   stop       - level; aborts playback to IDLE with sel=0, no done
//   pause      - level; freezes tick count and sel while playing
//   updown     - 1 ascending, 0 descending; sampled at start and at each step boundary
//   loop_en    - 1 wrap at the sequence end, 0 stop after one pass
//   sel        - current step index (0 is the silence entry while idle)
//   playing    - high in PLAY or HOLD
//   gate       - note-sounding window: PLAY and not in the trailing gap of the step
//   done       - one-cycle pulse after a one-shot pass completes
// Parameters: TICKS_PER_STEP >= 2, GAP_TICKS < TICKS_PER_STEP, LAST_STEP in 1..255.
module melody_step_sequencer
    import buzzer_pkg::*;
#(
    parameter int TICKS_PER_STEP = 12_500_000,
    parameter int GAP_TICKS      = 1_250_000,
    parameter int LAST_STEP      = DEF_LAST_STEP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              updown,
    input  logic              loop_en,
    output logic [STEP_W-1:0] sel,
    output logic              playing,
    output logic              gate,
    output logic              done
);

    localparam logic [STEP_W-1:0] LAST_SEL = STEP_W'(LAST_STEP);

    seq_state_t state;
    step_adv_t  adv;
    logic       tick_run;
    logic       tick_clear;
    logic       boundary;
    logic       gate_win;

    // The counter only moves on an unpaused, unstopped PLAY cycle; HOLD leaves it
    // untouched so the step resumes exactly where it was frozen.
    assign tick_run   = (state == ST_PLAY) && !stop && !pause;
    assign tick_clear = (state == ST_IDLE) || stop;

    step_tick_gen #(
        .TICKS_PER_STEP (TICKS_PER_STEP),
        .GAP_TICKS      (GAP_TICKS)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .run      (tick_run),
        .clear    (tick_clear),
        .boundary (boundary),
        .gate_win (gate_win)
    );

    // Candidate next index; only used on a boundary cycle. updown is read here, so a
    // direction change takes effect at the next boundary from the current sel.
    always_comb begin
        adv = step_advance(sel, updown, loop_en, LAST_SEL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            sel   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    sel <= '0;
                    if (start && !stop) begin
                        state <= ST_PLAY;
                        sel   <= updown ? '0 : LAST_SEL;
                    end
                end
                ST_PLAY: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        sel   <= '0;
                    end else if (pause) begin
                        state <= ST_HOLD;
                    end else if (boundary) begin
                        sel <= adv.sel;
                        if (adv.ended) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        sel   <= '0;
                    end else if (!pause) begin
                        state <= ST_PLAY;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    sel   <= '0;
                end
            endcase
        end
    end

    // Pure decodes of registered state and tick count: no input-to-output path.
    assign playing = (state != ST_IDLE);
    assign gate    = (state == ST_PLAY) && gate_win;

endmodule

// File: doc/melody_step_sequencer.md
# melody_step_sequencer

Step sequencer that produces the 8-bit note-step index consumed by the note-selection multiplexer in the microwave buzzer path. It replaces the free-running up/down counter with tempo-controlled stepping, start/stop/pause control, one-shot or looping playback and an articulation gate. The `gate` output lets the buzzer stage separate repeated notes. It sits directly upstream of the multiplexer's `sel` input.

## Interface
- `TICKS_PER_STEP`, 12_500_000: clk cycles per step (250 ms at 50 MHz); must be ≥ 2.
- `GAP_TICKS`, 1_250_000: cycles at the end of each step with `gate` low; must be < `TICKS_PER_STEP`.
- `LAST_STEP`, 20: highest step index; must be 1..255.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  level-sampled; when high in IDLE, playback begins.
- `stop`  in  1  level-sampled; when high, playback aborts to IDLE.
- `pause`  in  1  level; while high in PLAY or HOLD, the sequence is frozen.
- `updown`  in  1  1 = ascending, 0 = descending; sampled at start and at every step boundary.
- `loop_en`  in  1  1 = wrap at the end of the sequence, 0 = one-shot.
- `sel`  out  8  current step index, goes to the multiplexer `sel` input.
- `playing`  out  1  high in PLAY or HOLD.
- `gate`  out  1  note-sounding window.
- `done`  out  1  one-cycle pulse when a one-shot sequence completes.

## Operation
- The FSM has three states: IDLE, PLAY and HOLD. The internal `tick_cnt` counts 0..`TICKS_PER_STEP`-1.
- Input priority each cycle: stop > start > pause.
- IDLE:
  - `sel`=0 (the silence entry), `tick_cnt`=0.
  - When `start`=1, go to PLAY with `tick_cnt`=0.
  - The starting `sel` is 0 if `updown`=1, otherwise `LAST_STEP`.
- PLAY:
  - `tick_cnt` increments each cycle.
  - When `tick_cnt`=`TICKS_PER_STEP`-1 (boundary), `tick_cnt` goes to 0 and `sel` advances.
  - Ascending: `sel`+1. At `LAST_STEP`, `sel` goes to 0 if `loop_en`=1; otherwise the block goes to IDLE with `sel`=0 and pulses `done`.
  - Descending: `sel`-1. At 0, `sel` goes to `LAST_STEP` if `loop_en`=1; otherwise the block goes to IDLE with `sel`=0 and pulses `done`.
  - `pause`=1 moves to HOLD. That cycle's tick increment and any boundary advance do not happen.
- HOLD:
  - `tick_cnt` and `sel` are frozen.
  - Goes back to PLAY on the first cycle `pause`=0.
- `stop`=1 in PLAY or HOLD: go to IDLE, `sel`=0, `tick_cnt`=0, no `done`.
- `start` in PLAY or HOLD is ignored; it does not restart playback.
- Direction reversal mid-sequence takes effect at the next boundary, from the current `sel`. Arithmetic is 8-bit and never leaves the range 0..`LAST_STEP`.
- `gate` = (state==PLAY) && (`tick_cnt` < `TICKS_PER_STEP`-`GAP_TICKS`).
- `playing` = (state != IDLE).
- `gate` and `playing` are decodes of registers only, with no input-to-output combinational path.

## Timing
- Reset values: state IDLE, `sel`=0, `tick_cnt`=0, `playing`=0, `gate`=0, `done`=0.
- Reset mid-playback returns to these values immediately (asynchronous).
- `start` high at edge N: `playing`=1 and `sel` holds its start value after edge N; `gate`=1 from then on.
- A step lasts exactly `TICKS_PER_STEP` cycles of PLAY. Cycles spent in HOLD are not counted.
- `done` is registered: high for exactly the one cycle following the final boundary edge, coincident with `playing`=0.
- `start` and `stop` high in the same cycle in IDLE: stays in IDLE.
- `start` held high after a one-shot completes: restarts on the next edge. `done` is still pulsed.

## Structure
- Shared package `buzzer_pkg` holds:
  - the state enum (IDLE/PLAY/HOLD);
  - `STEP_W`=8;
  - the default `LAST_STEP`=20, which is also used by the multiplexer's case table.
- Sub-module `step_tick_gen` holds `tick_cnt` and produces `boundary` and `gate_win`, with `run` and `clear` inputs. The FSM and `sel` datapath stay in the top module.

## Test plan
All scenarios use `TICKS_PER_STEP`=4, `GAP_TICKS`=1, `LAST_STEP`=3.
- Reset during PLAY at `sel`=2 -> `sel`=0, `playing`=0, `gate`=0 immediately, before the next clock edge.
- Ascending one-shot: `start` pulse, `updown`=1, `loop_en`=0 -> `sel` reads 0,1,2,3, each for 4 cycles. `gate` pattern per step is 1,1,1,0. The cycle after the 16th PLAY cycle: `sel`=0, `done`=1 for one cycle, `playing`=0.
- Descending loop: `updown`=0, `loop_en`=1 -> `sel` reads 3,2,1,0,3,2,… and `done` never asserts.
- Pause: `pause` high for 5 cycles mid-step at `tick_cnt`=1 -> `sel` and `tick_cnt` frozen and `gate`=0 throughout. After release, the step completes after exactly 3 more PLAY cycles.
- `stop` at `sel`=2 in HOLD -> IDLE next edge, `sel`=0, `done`=0.
- `updown` flipped 1→0 while at `sel`=2 -> the next boundary gives `sel`=1. `start` pulsed during PLAY is ignored.
